// File: rtl/raw_tpg.sv
// Raw Bayer (RGGB) test-pattern video source: frame timing generator plus
// flat / colour-bar / ramp / moving-diagonal patterns for ISP bring-up.
module raw_tpg #(
    parameter int unsigned source_h = 1024,
    parameter int unsigned source_v = 1024,
    parameter int unsigned h_sync   = 40,
    parameter int unsigned h_bp     = 40,
    parameter int unsigned h_fp     = 40,
    parameter int unsigned v_sync   = 2,
    parameter int unsigned v_bp     = 4,
    parameter int unsigned v_fp     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] pattern_sel,
    output logic       out_vsync,
    output logic       out_hsync,
    output logic       out_den,
    output logic [7:0] out_data,
    output logic [7:0] frame_cnt,
    output logic       frame_done,
    output logic       busy
);

    localparam int unsigned H_TOTAL = h_sync + h_bp + source_h + h_fp;
    localparam int unsigned V_TOTAL = v_sync + v_bp + source_v + v_fp;
    localparam int unsigned H_OFF   = h_sync + h_bp;
    localparam int unsigned V_OFF   = v_sync + v_bp;
    localparam int unsigned BAR_W   = source_h / 8;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [HW-1:0]   hcnt;
    logic [VW-1:0]   vcnt;
    logic [1:0]      pat;
    logic [BW-1:0]   bar_pos;
    logic [2:0]      bar_idx;

    logic            h_last;
    logic            v_last;
    logic            frame_end;
    logic            hsync_c;
    logic            vsync_c;
    logic            h_act;
    logic            v_act;
    logic            den_c;
    logic [7:0]      px;
    logic [7:0]      py;
    logic [2:0]      bar_rgb;
    logic            bar_bit;
    logic [7:0]      comp;

    // Timing decode and pattern component for the current counter state.
    always_comb begin
        h_last    = (hcnt == HW'(H_TOTAL - 1));
        v_last    = (vcnt == VW'(V_TOTAL - 1));
        frame_end = h_last && v_last;
        hsync_c   = (hcnt < HW'(h_sync));
        vsync_c   = (vcnt < VW'(v_sync));
        h_act     = (hcnt >= HW'(H_OFF)) && (hcnt < HW'(H_OFF + source_h));
        v_act     = (vcnt >= VW'(V_OFF)) && (vcnt < VW'(V_OFF + source_v));
        den_c     = h_act && v_act;
        px        = 8'(hcnt - HW'(H_OFF));
        py        = 8'(vcnt - VW'(V_OFF));

        // {r,g,b} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
        case (bar_idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase

        case ({py[0], px[0]})
            2'b00:   bar_bit = bar_rgb[2];
            2'b11:   bar_bit = bar_rgb[0];
            default: bar_bit = bar_rgb[1];
        endcase

        case (pat)
            2'd0:    comp = 8'h80;
            2'd1:    comp = {8{bar_bit}};
            2'd2:    comp = px;
            default: comp = px + py + frame_cnt;
        endcase
    end

    // Control FSM, raster counters and registered video outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            hcnt       <= '0;
            vcnt       <= '0;
            pat        <= 2'd0;
            bar_pos    <= '0;
            bar_idx    <= 3'd0;
            out_vsync  <= 1'b0;
            out_hsync  <= 1'b0;
            out_den    <= 1'b0;
            out_data   <= 8'h00;
            frame_cnt  <= 8'h00;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                RUN, DRAIN: begin
                    if (h_last) begin
                        hcnt <= '0;
                        vcnt <= v_last ? '0 : vcnt + VW'(1);
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end

                    if (hcnt == '0 && vcnt == '0) begin
                        pat <= pattern_sel;
                    end

                    // Bar index advances every BAR_W active pixels; cleared outside the active span.
                    if (h_act) begin
                        if (bar_pos == BW'(BAR_W - 1)) begin
                            bar_pos <= '0;
                            bar_idx <= bar_idx + 3'd1;
                        end else begin
                            bar_pos <= bar_pos + BW'(1);
                        end
                    end else begin
                        bar_pos <= '0;
                        bar_idx <= 3'd0;
                    end

                    out_vsync  <= vsync_c;
                    out_hsync  <= hsync_c;
                    out_den    <= den_c;
                    out_data   <= den_c ? comp : 8'h00;
                    frame_done <= frame_end;
                    if (frame_end) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end

                    if (state == RUN) begin
                        if (!en) begin
                            if (frame_end) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end else begin
                        if (en) begin
                            state <= RUN;
                        end else if (frame_end) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    hcnt       <= '0;
                    vcnt       <= '0;
                    bar_pos    <= '0;
                    bar_idx    <= 3'd0;
                    out_vsync  <= 1'b0;
                    out_hsync  <= 1'b0;
                    out_den    <= 1'b0;
                    out_data   <= 8'h00;
                    frame_done <= 1'b0;
                    if (en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_raw_tpg.sv
// Directed bench for raw_tpg with a 16x4 active area (22 x 7 raster, 154 clocks/frame).
module tb_raw_tpg;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [1:0] pattern_sel;
    logic       out_vsync;
    logic       out_hsync;
    logic       out_den;
    logic [7:0] out_data;
    logic [7:0] frame_cnt;
    logic       frame_done;
    logic       busy;

    raw_tpg #(
        .source_h(16), .source_v(4),
        .h_sync(2), .h_bp(2), .h_fp(2),
        .v_sync(1), .v_bp(1), .v_fp(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .pattern_sel(pattern_sel),
        .out_vsync(out_vsync), .out_hsync(out_hsync), .out_den(out_den),
        .out_data(out_data), .frame_cnt(frame_cnt), .frame_done(frame_done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Hand-computed colour-bar lines (BAR_W = 2): even line R/G phase, odd line G/B phase.
    logic [127:0] bars_even = 128'hFF_FF_FF_FF_00_FF_00_FF_FF_00_FF_00_00_00_00_00;
    logic [127:0] bars_odd  = 128'hFF_FF_FF_00_FF_FF_FF_00_00_FF_00_00_00_FF_00_00;

    logic [7:0] pix [0:3][0:15];
    int n_hs, n_vs, n_den, den_off, n_done, idle_err, hs_err, vs_found;
    logic busy_late;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Capture one frame starting at the next out_vsync rise; ends on the frame's last clock.
    task automatic grab(input int off_t, input int on_t, input int sw_t, input logic [1:0] sw_val);
        logic last_vs;
        last_vs  = out_vsync;
        vs_found = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (out_vsync && !last_vs) begin
                vs_found = 1;
                break;
            end
            last_vs = out_vsync;
        end
        n_hs = 0; n_vs = 0; n_den = 0; den_off = -1; n_done = 0;
        idle_err = 0; hs_err = 0; busy_late = 1'b0;
        for (int t = 0; t < 154; t++) begin
            if (out_hsync) n_hs++;
            if (out_vsync) n_vs++;
            if (out_hsync != ((t % 22) < 2)) hs_err++;
            if (out_den) begin
                if (den_off < 0) den_off = t;
                if (n_den < 64) pix[n_den / 16][n_den % 16] = out_data;
                n_den++;
            end else if (out_data != 8'h00) begin
                idle_err++;
            end
            if (frame_done) n_done++;
            if (t == 152) busy_late = busy;
            if (t == off_t) en = 1'b0;
            if (t == on_t) en = 1'b1;
            if (t == sw_t) pattern_sel = sw_val;
            if (t < 153) @(negedge clk);
        end
    endtask

    function automatic logic [127:0] obs_line(input int y);
        logic [127:0] v;
        v = '0;
        for (int x = 0; x < 16; x++) v[127 - 8*x -: 8] = pix[y][x];
        return v;
    endfunction

    function automatic logic [127:0] exp_line(input int mode, input int y, input int cnt);
        logic [127:0] v;
        v = '0;
        for (int x = 0; x < 16; x++) begin
            case (mode)
                0: v[127 - 8*x -: 8] = 8'h80;
                2: v[127 - 8*x -: 8] = 8'(x);
                3: v[127 - 8*x -: 8] = 8'(x + y + cnt);
                default: v = (y % 2 == 0) ? bars_even : bars_odd;
            endcase
        end
        return v;
    endfunction

    task automatic chk_lines(input string tag, input int mode, input int cnt);
        for (int y = 0; y < 4; y++)
            chk($sformatf("%s_y%0d", tag, y), obs_line(y), exp_line(mode, y, cnt));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_vsync"}, 128'(out_vsync), 128'd0);
        chk({tag, "_hsync"}, 128'(out_hsync), 128'd0);
        chk({tag, "_den"},   128'(out_den),   128'd0);
        chk({tag, "_data"},  128'(out_data),  128'd0);
        chk({tag, "_done"},  128'(frame_done), 128'd0);
        chk({tag, "_busy"},  128'(busy),      128'd0);
    endtask

    int n_wrap_done;
    int wrap_err;
    logic [7:0] exp_cnt;

    initial begin
        reset_n = 1'b0; en = 1'b0; pattern_sel = 2'd0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_fcnt", 128'(frame_cnt), 128'd0);
        reset_n = 1'b1;
        @(negedge clk);
        en = 1'b1;

        // Frame 0: flat, full timing check
        grab(-1, -1, -1, 2'd0);
        chk("f0_vs_found", 128'(vs_found), 128'd1);
        chk("f0_hsync_cnt", 128'(n_hs), 128'd14);
        chk("f0_hsync_phase", 128'(hs_err), 128'd0);
        chk("f0_vsync_cnt", 128'(n_vs), 128'd22);
        chk("f0_den_off", 128'(den_off), 128'd48);
        chk("f0_den_cnt", 128'(n_den), 128'd64);
        chk("f0_idle_data", 128'(idle_err), 128'd0);
        chk("f0_done", 128'(n_done), 128'd1);
        chk_lines("flat", 0, 0);
        chk("f0_fcnt", 128'(frame_cnt), 128'd1);
        pattern_sel = 2'd1;

        grab(-1, -1, -1, 2'd0);
        chk_lines("bars", 1, 0);
        pattern_sel = 2'd3;

        grab(-1, -1, -1, 2'd0);
        chk_lines("diag", 3, 2);
        pattern_sel = 2'd2;

        grab(-1, -1, -1, 2'd0);
        chk_lines("ramp", 2, 0);
        pattern_sel = 2'd0;

        // Frame 4: switch to ramp while vcnt = 3; frame 5 shows it
        grab(-1, -1, 70, 2'd2);
        chk_lines("sw_hold", 0, 0);
        grab(-1, -1, -1, 2'd0);
        chk_lines("sw_next", 2, 0);

        // Frame 6: drop en at vcnt = 2, frame completes then idles
        grab(50, -1, -1, 2'd0);
        chk("drain_done", 128'(n_done), 128'd1);
        chk("drain_den_cnt", 128'(n_den), 128'd64);
        chk("drain_busy_late", 128'(busy_late), 128'd1);
        @(negedge clk);
        chk_idle_outputs("drained");
        chk("drained_fcnt", 128'(frame_cnt), 128'd7);
        repeat (5) @(negedge clk);
        chk("idle_busy", 128'(busy), 128'd0);
        en = 1'b1;

        // Frame 7: drain entered and cancelled; next frame must follow with no gap
        grab(30, 60, -1, 2'd0);
        chk("redo_vs_found", 128'(vs_found), 128'd1);
        chk("redo_done", 128'(n_done), 128'd1);
        chk_lines("redo", 2, 0);
        @(negedge clk);
        chk("nogap_vsync", 128'(out_vsync), 128'd1);
        chk("nogap_busy", 128'(busy), 128'd1);

        // Reset mid-line while den is high
        repeat (50) @(negedge clk);
        chk("pre_rst_den", 128'(out_den), 128'd1);
        #2 reset_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        chk("async_rst_fcnt", 128'(frame_cnt), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;

        grab(-1, -1, -1, 2'd0);
        chk("restart_vs_found", 128'(vs_found), 128'd1);
        chk("restart_den_off", 128'(den_off), 128'd48);
        chk("restart_done", 128'(n_done), 128'd1);
        chk("restart_fcnt", 128'(frame_cnt), 128'd1);

        // 255 more frames: frame_cnt steps once per frame_done and wraps to 0
        n_wrap_done = 0;
        wrap_err = 0;
        exp_cnt = 8'd1;
        for (int i = 0; i < 260 * 154 && n_wrap_done < 255; i++) begin
            @(negedge clk);
            if (frame_done) begin
                n_wrap_done++;
                exp_cnt = exp_cnt + 8'd1;
                if (frame_cnt != exp_cnt) wrap_err++;
            end
        end
        chk("wrap_done", 128'(n_wrap_done), 128'd255);
        chk("wrap_seq", 128'(wrap_err), 128'd0);
        chk("wrap_fcnt", 128'(frame_cnt), 128'd0);
        @(negedge clk);
        chk("wrap_done_pulse", 128'(frame_done), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
